fifo_flagged: RTL and testbench
===============================

Name: fifo_flagged

Overview:
Synchronous single-clock FIFO, the parametrised successor to the team's basic FIFO. It adds:
- non-power-of-two depth
- selectable first-word-fall-through (FWFT) read mode
- programmable almost-full and almost-empty thresholds
- an occupancy count output
- sticky overflow and underflow error flags

It sits between io_circuits producers and consumers (UART RX/TX, memory-mapped IO) and is a drop-in replacement for the standard-mode FIFO when FWFT=0.

Parameters:
- WIDTH, 8, data word width in bits (≥1).
- DEPTH, 32, number of entries (≥2; power of two not required).
- FWFT, 0, 0 = standard registered read; 1 = first-word-fall-through.
- AF_LEVEL, DEPTH-4, almost_full asserts when count ≥ AF_LEVEL (1..DEPTH).
- AE_LEVEL, 4, almost_empty asserts when count ≤ AE_LEVEL (0..DEPTH-1).
- PTR_W, $clog2(DEPTH), pointer width.
- CNT_W, $clog2(DEPTH+1), count width.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  reset: one clock; reset is synchronous and active-low.
- wr_en  in  1  write request.
- din  in  WIDTH  write data.
- full  out  1  count == DEPTH.
- almost_full  out  1  count ≥ AF_LEVEL.
- rd_en  in  1  read request.
- dout  out  WIDTH  read data.
- empty  out  1  count == 0.
- almost_empty  out  1  count ≤ AE_LEVEL.
- count  out  CNT_W  current occupancy.
- clr_err  in  1  synchronous clear of the sticky error flags.
- overflow  out  1  sticky: a write was attempted while full and was dropped.
- underflow  out  1  sticky: a read was attempted while empty and was ignored.

Behaviour:
- Reset (rst==0 at posedge):
  - rd_ptr=0, wr_ptr=0, count=0.
  - overflow=0, underflow=0.
  - Standard-mode dout register = 0.
  - Memory contents are not reset.
  - Reset overrides all other inputs, including mid-burst operation.
- Flags (full, empty, almost_full, almost_empty) are combinational decodes of the registered count. Their values after reset are full=0, empty=1, almost_full=0, almost_empty=1.
- Accepted write: wr_ok = wr_en && (!full || rd_ok).
  - Writing din into mem[wr_ptr] lands the word at the same edge.
- Accepted read: rd_ok = rd_en && !empty.
- Full with wr_en && rd_en: both accepted, count unchanged, no overflow.
- Empty with wr_en && rd_en: write accepted, read rejected, underflow set, count becomes 1.
- Pointer wrap: a pointer equal to DEPTH-1 advances to 0 (explicit compare, not natural rollover).
- Count update: count_next = count + wr_ok - rd_ok. Count never exceeds DEPTH and never goes below 0.
- Standard mode (FWFT=0):
  - dout is registered and loads mem[rd_ptr] on the edge where rd_ok is high, so data is valid the cycle after the read.
  - dout holds its value otherwise, including on rejected reads.
  - Data written on edge N is readable at the earliest with rd_en in cycle N+1, and appears on dout after edge N+1.
- FWFT mode (FWFT=1):
  - dout = mem[rd_ptr] combinationally whenever !empty. rd_en acts as "pop".
  - dout is don't-care while empty; the bench must not check it then.
  - Word written on edge N is visible on dout in cycle N+1.
- Sticky error flags:
  - overflow sets on wr_en && !wr_ok; underflow sets on rd_en && !rd_ok.
  - clr_err clears both. If a set event and clr_err occur in the same cycle, set wins.
  - Neither flag changes pointers or count.
- Elaboration checks:
  - Parameter violations stop elaboration: DEPTH<2, AF_LEVEL outside 1..DEPTH, AE_LEVEL outside 0..DEPTH-1.

Decomposition:
- Shared package fifo_pkg holds:
  - mode constants FIFO_STD=0 and FIFO_FWFT=1
  - the function computing clog2 of DEPTH+1 for count width
- One natural sub-module, fifo_wrap_ptr (parameters DEPTH, PTR_W; inputs clk, rst, inc; output ptr): modulo-DEPTH pointer, instantiated twice.
- The memory array and flag logic stay in the top.

Test Plan:
- Reset and fill, DEPTH=5, WIDTH=8, FWFT=0, AF=4, AE=1:
  - Hold rst=0 for 2 cycles -> count=0, empty=1, almost_empty=1, full=0, dout=0.
  - Write 0x11..0x15 -> count steps 1..5; almost_empty deasserts at count=2; almost_full at 4; full at 5.
- Overflow and error clear:
  - While full, write 0x99 -> overflow=1, count stays 5.
  - Read 5 words -> dout 0x11..0x15, each one cycle after its rd_en; 0x99 never appears.
  - Pulse clr_err -> overflow=0.
- Wrap-around at non-power-of-two depth:
  - Alternate write/read of 12 words 0x20..0x2B (pointers cross DEPTH-1 -> 0 twice) -> output order exact, count ≤ 1 throughout.
- Simultaneous events:
  - When full, wr_en=rd_en=1 with din=0xAA -> count stays 5, no overflow, 0xAA emerges after the 5 older words.
  - When empty, wr_en=rd_en=1 with din=0xBB -> count=1, underflow=1, dout unchanged.
- FWFT mode (FWFT=1):
  - Write 0x5A on edge N -> dout=0x5A and empty=0 in cycle N+1 with no rd_en.
  - rd_en pops it -> empty=1.
  - rd_en while empty -> underflow=1.
- Reset mid-operation:
  - With count=3 and an active write, assert rst=0 for one cycle -> next cycle count=0, empty=1, errors=0.
  - Subsequent write/read of 0x77 -> returns 0x77 (no stale words).

Source files
------------

// File: rtl/fifo_pkg.sv
// rtl/fifo_pkg.sv - shared constants and helpers for the flagged FIFO
package fifo_pkg;

    // Read-mode selectors for the FWFT parameter
    localparam int FIFO_STD  = 0;
    localparam int FIFO_FWFT = 1;

    // Width needed to hold an occupancy count of 0..depth inclusive
    function automatic int fifo_cnt_w(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/fifo_wrap_ptr.sv
// rtl/fifo_wrap_ptr.sv - modulo-DEPTH pointer with explicit wrap
module fifo_wrap_ptr #(
    parameter int DEPTH = 32,
    parameter int PTR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [PTR_W-1:0] ptr
);

    logic [PTR_W-1:0] r_ptr;

    // Advance on inc; the last slot returns to 0 so non-power-of-two depths work
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_ptr <= '0;
        end else if (inc) begin
            if (r_ptr == PTR_W'(DEPTH - 1)) begin
                r_ptr <= '0;
            end else begin
                r_ptr <= r_ptr + 1'b1;
            end
        end
    end

    assign ptr = r_ptr;

endmodule

// File: rtl/fifo_flagged.sv
// rtl/fifo_flagged.sv - single-clock FIFO with thresholds, count, FWFT and sticky errors
module fifo_flagged
    import fifo_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int DEPTH    = 32,
    parameter int FWFT     = FIFO_STD,
    parameter int AF_LEVEL = DEPTH - 4,
    parameter int AE_LEVEL = 4,
    parameter int PTR_W    = $clog2(DEPTH),
    parameter int CNT_W    = fifo_cnt_w(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] din,
    output logic             full,
    output logic             almost_full,
    input  logic             rd_en,
    output logic [WIDTH-1:0] dout,
    output logic             empty,
    output logic             almost_empty,
    output logic [CNT_W-1:0] count,
    input  logic             clr_err,
    output logic             overflow,
    output logic             underflow
);

    // Refuse to elaborate with nonsensical geometry or thresholds
    if (DEPTH < 2) begin : g_bad_depth
        $error("fifo_flagged: DEPTH must be at least 2");
    end
    if (AF_LEVEL < 1 || AF_LEVEL > DEPTH) begin : g_bad_af
        $error("fifo_flagged: AF_LEVEL must lie in 1..DEPTH");
    end
    if (AE_LEVEL < 0 || AE_LEVEL > DEPTH - 1) begin : g_bad_ae
        $error("fifo_flagged: AE_LEVEL must lie in 0..DEPTH-1");
    end

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [CNT_W-1:0] r_count;
    logic             r_overflow;
    logic             r_underflow;
    logic [PTR_W-1:0] w_wr_ptr;
    logic [PTR_W-1:0] w_rd_ptr;
    logic             w_full;
    logic             w_empty;
    logic             w_rd_ok;
    logic             w_wr_ok;

    assign w_full  = (r_count == CNT_W'(DEPTH));
    assign w_empty = (r_count == '0);

    // A read frees a slot in the same edge, so a full FIFO still takes a paired write
    assign w_rd_ok = rd_en && !w_empty;
    assign w_wr_ok = wr_en && (!w_full || w_rd_ok);

    fifo_wrap_ptr #(.DEPTH(DEPTH), .PTR_W(PTR_W)) u_wr_ptr (
        .clk (clk),
        .rst (rst),
        .inc (w_wr_ok),
        .ptr (w_wr_ptr)
    );

    fifo_wrap_ptr #(.DEPTH(DEPTH), .PTR_W(PTR_W)) u_rd_ptr (
        .clk (clk),
        .rst (rst),
        .inc (w_rd_ok),
        .ptr (w_rd_ptr)
    );

    // Storage is not cleared; reset only blocks the write so no stale word is queued
    always_ff @(posedge clk) begin
        if (rst && w_wr_ok) begin
            r_mem[w_wr_ptr] <= din;
        end
    end

    // Occupancy tracks accepted writes minus accepted reads
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_count <= '0;
        end else begin
            case ({w_wr_ok, w_rd_ok})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Sticky error flags; a new error in the clearing cycle keeps the flag set
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (wr_en && !w_wr_ok) begin
                r_overflow <= 1'b1;
            end else if (clr_err) begin
                r_overflow <= 1'b0;
            end
            if (rd_en && !w_rd_ok) begin
                r_underflow <= 1'b1;
            end else if (clr_err) begin
                r_underflow <= 1'b0;
            end
        end
    end

    if (FWFT == FIFO_FWFT) begin : g_fwft
        // Head of queue is always presented; meaningless while empty
        assign dout = r_mem[w_rd_ptr];
    end else begin : g_std
        logic [WIDTH-1:0] r_dout;

        // Registered read: loads only on an accepted read, otherwise holds
        always_ff @(posedge clk) begin
            if (!rst) begin
                r_dout <= '0;
            end else if (w_rd_ok) begin
                r_dout <= r_mem[w_rd_ptr];
            end
        end

        assign dout = r_dout;
    end

    assign count        = r_count;
    assign full         = w_full;
    assign empty        = w_empty;
    assign almost_full  = (r_count >= CNT_W'(AF_LEVEL));
    assign almost_empty = (r_count <= CNT_W'(AE_LEVEL));
    assign overflow     = r_overflow;
    assign underflow    = r_underflow;

endmodule

// File: tb/tb_fifo_flagged.sv
// tb/tb_fifo_flagged.sv - directed scoreboard bench for standard and FWFT fifo_flagged
module tb_fifo_flagged;

    localparam int D  = 5;
    localparam int AF = 4;
    localparam int AE = 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // standard-mode instance signals
    logic       rst = 1'b0, wr_en = 1'b0, rd_en = 1'b0, clr_err = 1'b0;
    logic [7:0] din = '0;
    logic       full, almost_full, empty, almost_empty, overflow, underflow;
    logic [7:0] dout;
    logic [2:0] count;

    // FWFT instance signals
    logic       f_rst = 1'b0, f_wr_en = 1'b0, f_rd_en = 1'b0, f_clr_err = 1'b0;
    logic [7:0] f_din = '0;
    logic       f_full, f_almost_full, f_empty, f_almost_empty, f_overflow, f_underflow;
    logic [7:0] f_dout;
    logic [2:0] f_count;

    fifo_flagged #(.WIDTH(8), .DEPTH(D), .FWFT(0), .AF_LEVEL(AF), .AE_LEVEL(AE)) u_std (
        .clk(clk), .rst(rst), .wr_en(wr_en), .din(din), .full(full),
        .almost_full(almost_full), .rd_en(rd_en), .dout(dout), .empty(empty),
        .almost_empty(almost_empty), .count(count), .clr_err(clr_err),
        .overflow(overflow), .underflow(underflow)
    );

    fifo_flagged #(.WIDTH(8), .DEPTH(D), .FWFT(1), .AF_LEVEL(AF), .AE_LEVEL(AE)) u_fwft (
        .clk(clk), .rst(f_rst), .wr_en(f_wr_en), .din(f_din), .full(f_full),
        .almost_full(f_almost_full), .rd_en(f_rd_en), .dout(f_dout), .empty(f_empty),
        .almost_empty(f_almost_empty), .count(f_count), .clr_err(f_clr_err),
        .overflow(f_overflow), .underflow(f_underflow)
    );

    int vectors = 0;
    int miscompares = 0;

    // reference model state
    int         m_cnt = 0;
    logic [7:0] q[$];
    logic [7:0] m_dout = '0;
    logic       m_ov = 1'b0, m_uf = 1'b0;

    int         fm_cnt = 0;
    logic [7:0] fq[$];
    logic       fm_ov = 1'b0, fm_uf = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input logic rn, input logic wr, input logic [7:0] d,
                       input logic rd, input logic clr);
        logic rok, wok;
        rst = rn; wr_en = wr; din = d; rd_en = rd; clr_err = clr;
        if (!rn) begin
            m_cnt = 0; q.delete(); m_dout = '0; m_ov = 1'b0; m_uf = 1'b0;
        end else begin
            rok = rd && (m_cnt > 0);
            wok = wr && ((m_cnt < D) || rok);
            if (rok) m_dout = q.pop_front();
            if (wok) q.push_back(d);
            m_cnt = m_cnt + int'(wok) - int'(rok);
            m_ov = (wr && !wok) ? 1'b1 : (clr ? 1'b0 : m_ov);
            m_uf = (rd && !rok) ? 1'b1 : (clr ? 1'b0 : m_uf);
        end
        @(posedge clk); #1;
        rst = 1'b1; wr_en = 1'b0; rd_en = 1'b0; clr_err = 1'b0;
        chk("std_count", count, m_cnt);
        chk("std_full", full, m_cnt == D);
        chk("std_almost_full", almost_full, m_cnt >= AF);
        chk("std_empty", empty, m_cnt == 0);
        chk("std_almost_empty", almost_empty, m_cnt <= AE);
        chk("std_dout", dout, m_dout);
        chk("std_overflow", overflow, m_ov);
        chk("std_underflow", underflow, m_uf);
    endtask

    task automatic fcyc(input logic rn, input logic wr, input logic [7:0] d,
                        input logic rd, input logic clr);
        logic rok, wok;
        f_rst = rn; f_wr_en = wr; f_din = d; f_rd_en = rd; f_clr_err = clr;
        if (!rn) begin
            fm_cnt = 0; fq.delete(); fm_ov = 1'b0; fm_uf = 1'b0;
        end else begin
            rok = rd && (fm_cnt > 0);
            wok = wr && ((fm_cnt < D) || rok);
            if (rok) void'(fq.pop_front());
            if (wok) fq.push_back(d);
            fm_cnt = fm_cnt + int'(wok) - int'(rok);
            fm_ov = (wr && !wok) ? 1'b1 : (clr ? 1'b0 : fm_ov);
            fm_uf = (rd && !rok) ? 1'b1 : (clr ? 1'b0 : fm_uf);
        end
        @(posedge clk); #1;
        f_rst = 1'b1; f_wr_en = 1'b0; f_rd_en = 1'b0; f_clr_err = 1'b0;
        chk("fwft_count", f_count, fm_cnt);
        chk("fwft_empty", f_empty, fm_cnt == 0);
        chk("fwft_full", f_full, fm_cnt == D);
        chk("fwft_overflow", f_overflow, fm_ov);
        chk("fwft_underflow", f_underflow, fm_uf);
        if (fm_cnt > 0) chk("fwft_dout", f_dout, fq[0]);
    endtask

    initial begin
        // reset held for two cycles
        cyc(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);

        // fill to full, watching the threshold flags
        for (int i = 0; i < D; i++) cyc(1'b1, 1'b1, 8'h11 + 8'(i), 1'b0, 1'b0);

        // overflow attempt, then drain and clear the sticky flag
        cyc(1'b1, 1'b1, 8'h99, 1'b0, 1'b0);
        for (int i = 0; i < D; i++) cyc(1'b1, 1'b0, 8'h00, 1'b1, 1'b0);
        cyc(1'b1, 1'b0, 8'h00, 1'b0, 1'b1);

        // alternating traffic wraps both pointers twice
        for (int i = 0; i < 12; i++) begin
            cyc(1'b1, 1'b1, 8'h20 + 8'(i), 1'b0, 1'b0);
            cyc(1'b1, 1'b0, 8'h00, 1'b1, 1'b0);
        end

        // simultaneous write and read while full
        for (int i = 0; i < D; i++) cyc(1'b1, 1'b1, 8'h30 + 8'(i), 1'b0, 1'b0);
        cyc(1'b1, 1'b1, 8'hAA, 1'b1, 1'b0);
        for (int i = 0; i < D; i++) cyc(1'b1, 1'b0, 8'h00, 1'b1, 1'b0);

        // simultaneous write and read while empty
        cyc(1'b1, 1'b1, 8'hBB, 1'b1, 1'b0);
        cyc(1'b1, 1'b0, 8'h00, 1'b1, 1'b1);

        // reset in the middle of a write burst
        for (int i = 0; i < 3; i++) cyc(1'b1, 1'b1, 8'h40 + 8'(i), 1'b0, 1'b0);
        cyc(1'b1, 1'b1, 8'h99, 1'b1, 1'b0);
        cyc(1'b0, 1'b1, 8'h55, 1'b0, 1'b0);
        cyc(1'b1, 1'b1, 8'h77, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 8'h00, 1'b1, 1'b0);
        cyc(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);

        // first-word-fall-through instance
        fcyc(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        fcyc(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        fcyc(1'b1, 1'b1, 8'h5A, 1'b0, 1'b0);
        fcyc(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
        fcyc(1'b1, 1'b0, 8'h00, 1'b1, 1'b0);
        fcyc(1'b1, 1'b0, 8'h00, 1'b1, 1'b0);
        fcyc(1'b1, 1'b1, 8'hC1, 1'b0, 1'b1);
        fcyc(1'b1, 1'b1, 8'hC2, 1'b0, 1'b0);
        fcyc(1'b1, 1'b1, 8'hC3, 1'b1, 1'b0);
        fcyc(1'b1, 1'b0, 8'h00, 1'b1, 1'b0);
        fcyc(1'b1, 1'b0, 8'h00, 1'b1, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
